// File: rtl/result_uart_tx.sv
// result_uart_tx: valid/ready result byte in, LSB-first 8N1 frame out on tx.
// Define RESULT_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module result_uart_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

`ifdef RESULT_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
`ifdef RESULT_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic accept;
  logic last;
  logic load;

  always_comb begin
    accept      = data_valid && !hold_full_q;
    last        = (cnt_q == CNT_LAST);
    load        = 1'b0;
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`ifdef RESULT_TX_PARITY_EN
    par_d       = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (last) state_d = DATA;
      end
      DATA: begin
        if (last) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RESULT_TX_PARITY_EN
      PARITY: begin
        if (last) state_d = STOP;
      end
`endif
      STOP: begin
        if (last) begin
          if (hold_full_q) begin
            state_d = START;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every bit period ends on last, so reloading there restarts each state.
    if (state_q == IDLE || last) cnt_d = '0;
    else                         cnt_d = cnt_q + CW'(1);

    if (load) begin
      shift_d     = hold_q;
      bit_d       = 3'd0;
      hold_full_d = 1'b0;
`ifdef RESULT_TX_PARITY_EN
      par_d       = ^hold_q;
`endif
    end
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef RESULT_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_q != IDLE) || hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
`ifdef RESULT_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
`ifdef RESULT_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign data_ready = !hold_full_q;
  assign tx         = tx_q;
  assign busy       = busy_q;

endmodule
